// File: rtl/adder_pkg.sv
//============================================================================
// Module      : adder_pkg
// Description : Shared types and helpers for the 32-bit adder and its
//               operand conditioning stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package adder_pkg;

   localparam int ADDER_WIDTH = 32;
   localparam int MAX_WIDTH   = 128;

   localparam logic [ADDER_WIDTH-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_INC = 2'd2,
      OP_DEC = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_ONE   = 2'd1,
      SB_FULL  = 2'd2
   } skid_state_e;

   typedef struct packed {
      alu_op_e                op;
      logic [ADDER_WIDTH-1:0] a;
      logic [ADDER_WIDTH-1:0] b;
      logic                   cin;
      logic                   par_err;
   } operand_entry_t;

   typedef struct packed {
      logic [ADDER_WIDTH-1:0] a;
      logic [ADDER_WIDTH-1:0] b_eff;
      logic                   cin;
   } mapped_operands_t;

   // Callers zero-extend narrower operands; zeros do not change even parity.
   function automatic logic parity(input logic [MAX_WIDTH-1:0] v);
      return ^v;
   endfunction

   function automatic mapped_operands_t map_operands(
      input alu_op_e                op,
      input logic [ADDER_WIDTH-1:0] a,
      input logic [ADDER_WIDTH-1:0] b
   );
      mapped_operands_t m;
      m.a = a;
      case (op)
         OP_ADD:  begin m.b_eff = b;        m.cin = 1'b0; end
         OP_SUB:  begin m.b_eff = ~b;       m.cin = 1'b1; end
         OP_INC:  begin m.b_eff = '0;       m.cin = 1'b1; end
         default: begin m.b_eff = ALL_ONES; m.cin = 1'b0; end
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_operand_stage_skid.sv
//============================================================================
// Module      : skid_buffer_2
// Description : Generic 2-entry valid/ready register slice (main + skid).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module skid_buffer_2
   import adder_pkg::*;
#(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [PAYLOAD_W-1:0] i_in_data,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [PAYLOAD_W-1:0] o_out_data
);

   skid_state_e          r_state;
   skid_state_e          w_state_next;
   logic [PAYLOAD_W-1:0] r_main;
   logic [PAYLOAD_W-1:0] r_skid;
   logic                 w_accept;
   logic                 w_emit;
   logic                 w_load_main_in;
   logic                 w_load_main_skid;
   logic                 w_load_skid;

   assign w_accept = i_in_valid && o_in_ready;
   assign w_emit   = o_out_valid && i_out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SB_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SB_EMPTY: if (w_accept) w_state_next = SB_ONE;
         SB_ONE: begin
            if (w_accept && !w_emit)      w_state_next = SB_FULL;
            else if (!w_accept && w_emit) w_state_next = SB_EMPTY;
         end
         SB_FULL:  if (w_emit) w_state_next = SB_ONE;
         default:  w_state_next = SB_EMPTY;
      endcase
   end

   // Handshake outputs decode only the state register, keeping ready/valid
   // free of combinational paths from the opposite side.
   always_comb begin
      o_out_valid      = (r_state == SB_ONE) || (r_state == SB_FULL);
      o_in_ready       = (r_state != SB_FULL);
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         SB_EMPTY: w_load_main_in = w_accept;
         SB_ONE: begin
            w_load_main_in = w_accept && w_emit;
            w_load_skid    = w_accept && !w_emit;
         end
         SB_FULL:  w_load_main_skid = w_emit;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= i_in_data;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= i_in_data;
         end
      end
   end

   assign o_out_data = r_main;

endmodule

`default_nettype wire

// File: rtl/adder_operand_stage.sv
//============================================================================
// Module      : adder_operand_stage
// Description : Maps ALU requests onto adder operands, checks parity and
//               registers the result through a 2-entry skid buffer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module adder_operand_stage
   import adder_pkg::*;
#(
   parameter int WIDTH     = ADDER_WIDTH,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_op,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_par_a,
   input  logic                 in_par_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_op,
   output logic [WIDTH-1:0]     out_a,
   output logic [WIDTH-1:0]     out_b,
   output logic                 out_cin,
   output logic                 out_par_err,
   output logic                 err_sticky,
   input  logic                 err_clr,
   output logic [CNT_WIDTH-1:0] txn_count
);

   localparam int PAYLOAD_W = 2 + 2 * WIDTH + 2;

   logic [MAX_WIDTH-1:0] w_a_ext;
   logic [MAX_WIDTH-1:0] w_b_ext;
   logic                 w_par_err;
   logic [WIDTH-1:0]     w_map_a;
   logic [WIDTH-1:0]     w_map_b;
   logic                 w_map_cin;
   logic [PAYLOAD_W-1:0] w_in_payload;
   logic [PAYLOAD_W-1:0] w_out_payload;
   logic                 w_accept;
   logic                 w_emit;
   logic                 r_err_sticky;
   logic [CNT_WIDTH-1:0] r_txn_count;

   always_comb begin
      w_a_ext              = '0;
      w_b_ext              = '0;
      w_a_ext[WIDTH-1:0]   = in_a;
      w_b_ext[WIDTH-1:0]   = in_b;
   end

   assign w_par_err = (parity(w_a_ext) != in_par_a) | (parity(w_b_ext) != in_par_b);

   generate
      if (WIDTH == ADDER_WIDTH) begin : g_native_map
         mapped_operands_t w_mapped;
         assign w_mapped  = map_operands(alu_op_e'(in_op), in_a, in_b);
         assign w_map_a   = w_mapped.a;
         assign w_map_b   = w_mapped.b_eff;
         assign w_map_cin = w_mapped.cin;
      end else begin : g_generic_map
         // Same mapping as map_operands, at a width other than the adder's.
         always_comb begin
            w_map_a = in_a;
            case (alu_op_e'(in_op))
               OP_ADD:  begin w_map_b = in_b;  w_map_cin = 1'b0; end
               OP_SUB:  begin w_map_b = ~in_b; w_map_cin = 1'b1; end
               OP_INC:  begin w_map_b = '0;    w_map_cin = 1'b1; end
               default: begin w_map_b = '1;    w_map_cin = 1'b0; end
            endcase
         end
      end
   endgenerate

   // Field order matches operand_entry_t.
   assign w_in_payload = {in_op, w_map_a, w_map_b, w_map_cin, w_par_err};

   skid_buffer_2 #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (w_in_payload),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (w_out_payload)
   );

   assign {out_op, out_a, out_b, out_cin, out_par_err} = w_out_payload;

   assign w_accept = in_valid && in_ready;
   assign w_emit   = out_valid && out_ready;

   // Set takes priority so a bad request is never lost to a concurrent clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_sticky <= 1'b0;
      end else if (w_accept && w_par_err) begin
         r_err_sticky <= 1'b1;
      end else if (err_clr) begin
         r_err_sticky <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_txn_count <= '0;
      end else if (w_emit) begin
         r_txn_count <= r_txn_count + 1'b1;
      end
   end

   assign err_sticky = r_err_sticky;
   assign txn_count  = r_txn_count;

endmodule

`default_nettype wire

// File: tb/tb_adder_operand_stage.sv
//============================================================================
// Module      : tb_adder_operand_stage
// Description : Directed self-checking bench for adder_operand_stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_adder_operand_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'd0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_par_a = 1'b0;
   logic        in_par_b = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  out_op;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic        out_cin;
   logic        out_par_err;
   logic        err_sticky;
   logic        err_clr = 1'b0;
   logic [15:0] txn_count;

   int n_tests = 0;
   int n_fail  = 0;

   adder_operand_stage #(.WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_par_a    (in_par_a),
      .in_par_b    (in_par_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_op      (out_op),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_cin     (out_cin),
      .out_par_err (out_par_err),
      .err_sticky  (err_sticky),
      .err_clr     (err_clr),
      .txn_count   (txn_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        pa;
      logic        pb;
      logic [31:0] exp_b;
      logic        exp_cin;
      logic        exp_perr;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      err_clr   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic pa, input logic pb);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_par_a = pa;
      in_par_b = pb;
   endtask

   initial begin
      logic [15:0] exp_txn;
      logic        exp_sticky;
      logic [31:0] got[$];
      logic        will_accept;
      int          cyc;

      //            op     a             b             pa    pb    exp_b         cin   perr
      vecs[0] = '{2'd0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
      vecs[1] = '{2'd1, 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0};
      vecs[2] = '{2'd2, 32'h7FFF_FFFF, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[3] = '{2'd3, 32'h0000_0000, 32'h0000_AAAA, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[4] = '{2'd0, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
      vecs[5] = '{2'd1, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b1};

      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_op", out_op, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_cin", out_cin, 0);
      chk("rst_par_err", out_par_err, 0);
      chk("rst_err_sticky", err_sticky, 0);
      chk("rst_txn_count", txn_count, 0);

      out_ready  = 1'b1;
      exp_txn    = '0;
      exp_sticky = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pa, vecs[i].pb);
         tick();
         in_valid   = 1'b0;
         exp_sticky = exp_sticky | vecs[i].exp_perr;
         chk($sformatf("v%0d_out_valid", i), out_valid, 1);
         chk($sformatf("v%0d_out_op", i), out_op, vecs[i].op);
         chk($sformatf("v%0d_out_a", i), out_a, vecs[i].a);
         chk($sformatf("v%0d_out_b", i), out_b, vecs[i].exp_b);
         chk($sformatf("v%0d_out_cin", i), out_cin, vecs[i].exp_cin);
         chk($sformatf("v%0d_par_err", i), out_par_err, vecs[i].exp_perr);
         chk($sformatf("v%0d_err_sticky", i), err_sticky, exp_sticky);
         tick();
         exp_txn++;
         chk($sformatf("v%0d_txn_count", i), txn_count, exp_txn);
         chk($sformatf("v%0d_drained", i), out_valid, 0);
      end

      // Clear alone, then clear racing a new bad request.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_sticky", err_sticky, 0);
      drive(2'd0, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
      err_clr = 1'b1;
      tick();
      in_valid = 1'b0;
      err_clr  = 1'b0;
      chk("clr_vs_set_sticky", err_sticky, 1);
      chk("clr_vs_set_par_err", out_par_err, 1);
      tick();

      // Reset while FULL.
      out_ready = 1'b0;
      drive(2'd0, 32'h0000_0011, 32'h0, 1'b0, 1'b0);
      tick();
      drive(2'd0, 32'h0000_0022, 32'h0, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("full_in_ready", in_ready, 0);
      chk("full_out_a_held", out_a, 32'h11);
      chk("full_sticky", err_sticky, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_txn", txn_count, 0);
      chk("async_rst_sticky", err_sticky, 0);
      chk("async_rst_out_a", out_a, 0);
      tick();
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      drive(2'd0, 32'h0000_0009, 32'h0000_0004, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_out_a", out_a, 32'h9);
      chk("post_rst_out_b", out_b, 32'h4);
      chk("post_rst_par_err", out_par_err, 0);
      tick();
      chk("post_rst_txn", txn_count, 1);

      // Backpressure: three requests with the adder stalled.
      do_reset();
      drive(2'd0, 32'h1, 32'h0, 1'b1, 1'b0);
      tick();
      chk("bp_ready_after_1", in_ready, 1);
      drive(2'd0, 32'h2, 32'h0, 1'b1, 1'b0);
      tick();
      chk("bp_ready_drop", in_ready, 0);
      drive(2'd0, 32'h3, 32'h0, 1'b0, 1'b0);
      tick();
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_stall_out_a", out_a, 32'h1);
      chk("bp_stall_valid", out_valid, 1);
      out_ready = 1'b1;
      cyc = 0;
      while (got.size() < 3 && cyc < 12) begin
         will_accept = in_valid && in_ready;
         if (out_valid && out_ready) got.push_back(out_a);
         tick();
         if (will_accept) in_valid = 1'b0;
         cyc++;
      end
      chk("bp_emit_count", 64'(got.size()), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_order_%0d", i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, 32'(i + 1));
      end
      chk("bp_input_taken", in_valid, 0);
      chk("bp_txn_count", txn_count, 3);
      chk("bp_empty", out_valid, 0);
      chk("bp_ready_back", in_ready, 1);

      // Stream to the counter wrap point at full throughput.
      do_reset();
      out_ready = 1'b1;
      drive(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc = 0;
      while (txn_count != 16'hFFFF && cyc < 70000) begin
         tick();
         cyc++;
      end
      chk("wrap_reached_ffff", txn_count, 16'hFFFF);
      chk("wrap_throughput_cycles", 64'(cyc), 65536);
      in_valid = 1'b0;
      chk("wrap_pending_valid", out_valid, 1);
      tick();
      chk("wrap_to_zero", txn_count, 0);
      chk("wrap_drained", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
